// File: rtl/secded_encoder_stream.sv
// Extended-Hamming SECDED encoder with a valid/ready stream interface, an output
// FIFO and a saturating encoded-word counter. Define ENC_ERR_INJECT_EN to add inj_mask.
module secded_encoder_stream #(
  parameter int DATA_W     = 11,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16,
  // Smallest R with 2^R >= DATA_W+R+1, written out for the legal DATA_W range.
  localparam int R    = (DATA_W <= 4)  ? 3 :
                        (DATA_W <= 11) ? 4 :
                        (DATA_W <= 26) ? 5 :
                        (DATA_W <= 57) ? 6 : 7,
  localparam int CW_W = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   data_out,
  output logic [CNT_W-1:0]  enc_count
`ifdef ENC_ERR_INJECT_EN
  ,
  input  logic [CW_W-1:0]   inj_mask
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CIW = $clog2(CW_W);
  localparam int DIW = $clog2(DATA_W);

  // Data bits fill the non-power-of-two positions from index 3 upward; each
  // Hamming parity covers the indices with its bit set, index 0 makes parity even.
  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic            p;
    int              n;
    int              pk;
    cw = '0;
    n  = 0;
    for (int j = 3; j < CW_W; j++) begin
      if ((j & (j - 1)) != 0) begin
        cw[j[CIW-1:0]] = d[n[DIW-1:0]];
        n = n + 1;
      end
    end
    for (int k = 0; k < R; k++) begin
      p = 1'b0;
      for (int j = 1; j < CW_W; j++) begin
        if (((j >> k) & 1) == 1) p = p ^ cw[j[CIW-1:0]];
      end
      pk = 1 << k;
      cw[pk[CIW-1:0]] = p;
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  logic [CW_W-1:0] cw_push;
  logic [CW_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     wr_nxt;
  logic [AW:0]     rd_nxt;
  logic [CW_W-1:0] dout_q;
  logic [CW_W-1:0] head_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  always_comb begin
    cw_push = encode(data_in);
`ifdef ENC_ERR_INJECT_EN
    cw_push = cw_push ^ inj_mask;
`endif
  end

  // Handshake: a beat transfers on a cycle where valid and ready are both high.
  // in_ready depends only on en and registered occupancy, never on out_ready.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = rst_n & en & ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_nxt    = wr_ptr + {{AW{1'b0}}, push};
  assign rd_nxt    = rd_ptr + {{AW{1'b0}}, pop};

  // A word pushed into an otherwise-empty slot becomes the head immediately.
  always_comb begin
    head_nxt = mem[rd_nxt[AW-1:0]];
    if (push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) head_nxt = cw_push;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cw_push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout_q <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      // Output register holds the last head once the FIFO drains.
      if (wr_nxt != rd_nxt) dout_q <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign data_out  = dout_q;
  assign enc_count = cnt_q;

endmodule

// File: tb/tb_secded_encoder_stream.sv
// Bench for secded_encoder_stream: directed steps plus randomized traffic checked
// against a queue-based reference model and a spec-level encoder.
module tb_secded_encoder_stream;

  localparam int DW = 11;
  localparam int CW = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] data_out;
  logic [3:0]    enc_count;
  logic [CW-1:0] inj_mask = '0;

  int tests = 0;
  int fails = 0;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] last_out;
  int            pushes;

  always #5 clk = ~clk;

  secded_encoder_stream #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .enc_count(enc_count)
`ifdef ENC_ERR_INJECT_EN
    ,
    .inj_mask(inj_mask)
`endif
  );

  // Reference encoder built directly from the position rules of the code.
  function automatic logic [CW-1:0] ref_encode(input logic [DW-1:0] d);
    int bits[CW];
    int n;
    int par;
    logic [CW-1:0] cw;
    for (int j = 0; j < CW; j++) bits[j] = 0;
    n = 0;
    for (int j = 3; j < CW; j++) begin
      if ($countones(j) != 1) begin
        bits[j] = int'(d[n]);
        n++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      par = 0;
      for (int j = 1; j < CW; j++)
        if (j != (1 << k) && ((j / (1 << k)) % 2 == 1)) par += bits[j];
      bits[1 << k] = par % 2;
    end
    par = 0;
    for (int j = 1; j < CW; j++) par += bits[j];
    bits[0] = par % 2;
    for (int j = 0; j < CW; j++) cw[j] = (bits[j] != 0);
    return cw;
  endfunction

  function automatic logic [3:0] cnt_exp();
    return (pushes > 15) ? 4'hF : 4'(pushes);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check pre-edge outputs, advance model, check counter.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic e,
                       input logic ordy, input logic [CW-1:0] cw, output logic acc);
    logic exp_rdy;
    logic exp_ov;
    logic pop;
    in_valid = v;
    data_in = d;
    en = e;
    out_ready = ordy;
    #1;
    exp_rdy = e && (exp_q.size() < DEPTH);
    exp_ov = (exp_q.size() != 0);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    chk("data_out", {48'd0, data_out}, {48'd0, (exp_ov ? exp_q[0] : last_out)});
    acc = v && exp_rdy;
    pop = exp_ov && ordy;
    @(posedge clk);
    #1;
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(cw ^ inj_mask);
      pushes++;
    end
    if (exp_q.size() != 0) last_out = exp_q[0];
    chk("enc_count", {60'd0, enc_count}, {60'd0, cnt_exp()});
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    en = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data_out", {48'd0, data_out}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_enc_count", {60'd0, enc_count}, 64'd0);
    exp_q.delete();
    last_out = '0;
    pushes = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    logic [DW-1:0] d;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic [DW-1:0] dc;
    int guard;
    in_valid = 1'b0;
    data_in = '0;
    en = 1'b1;
    out_ready = 1'b1;
    last_out = '0;
    pushes = 0;

    do_reset();

    // Known codewords, each followed by an idle cycle showing the output.
    cycle(1'b1, 11'h000, 1'b1, 1'b1, 16'h0000, acc);
    cycle(1'b0, 11'h000, 1'b1, 1'b1, 16'h0000, acc);
    cycle(1'b1, 11'h001, 1'b1, 1'b1, 16'h000F, acc);
    cycle(1'b0, 11'h000, 1'b1, 1'b1, 16'h0000, acc);
    cycle(1'b1, 11'h400, 1'b1, 1'b1, 16'h8117, acc);
    cycle(1'b0, 11'h000, 1'b1, 1'b1, 16'h0000, acc);
    cycle(1'b1, 11'h7FF, 1'b1, 1'b1, 16'hFFFF, acc);
    cycle(1'b0, 11'h000, 1'b1, 1'b1, 16'h0000, acc);
    cycle(1'b0, 11'h000, 1'b1, 1'b1, 16'h0000, acc);

    // Backpressure: third word refused while full, even on the pop cycle.
    da = 11'h2A5; db = 11'h15A; dc = 11'h3C3;
    cycle(1'b1, da, 1'b1, 1'b0, ref_encode(da), acc);
    cycle(1'b1, db, 1'b1, 1'b0, ref_encode(db), acc);
    cycle(1'b1, dc, 1'b1, 1'b0, ref_encode(dc), acc);
    chk("bp_third_refused_in_ready", {63'd0, in_ready}, 64'd0);
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 6) begin
      cycle(1'b1, dc, 1'b1, 1'b1, ref_encode(dc), acc);
      guard++;
    end
    chk("bp_third_accept_bound", {63'd0, acc}, 64'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b1, '0, acc);

    // en low: buffered word drains, new words ignored, counter frozen.
    d = 11'h0F0;
    cycle(1'b1, d, 1'b1, 1'b0, ref_encode(d), acc);
    for (int i = 0; i < 3; i++) cycle(1'b1, 11'h555, 1'b0, 1'b1, ref_encode(11'h555), acc);

    // Reset with two words buffered.
    cycle(1'b1, 11'h123, 1'b1, 1'b0, ref_encode(11'h123), acc);
    cycle(1'b1, 11'h321, 1'b1, 1'b0, ref_encode(11'h321), acc);
    do_reset();

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      d = DW'($urandom_range(0, 2047));
      cycle(1'b1, d, 1'b1, 1'b1, ref_encode(d), acc);
    end
    chk("enc_count_saturated", {60'd0, enc_count}, 64'hF);

`ifdef ENC_ERR_INJECT_EN
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1, '0, acc);
    inj_mask = 16'h0008;
    cycle(1'b1, 11'h000, 1'b1, 1'b0, 16'h0000, acc);
    inj_mask = '0;
    cycle(1'b0, '0, 1'b1, 1'b0, '0, acc);
    chk("inject_codeword", {48'd0, data_out}, 64'h0008);
    cycle(1'b0, '0, 1'b1, 1'b1, '0, acc);
`endif

    // Randomized traffic after a fresh reset.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      d = DW'($urandom_range(0, 2047));
      cycle(1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ref_encode(d), acc);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b1, '0, acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
